// File: rtl/stack_controller.sv
// Stack-unit control block: runs a 1024x32 MEMORIA array as a hardware LIFO,
// taking commands over valid/ready and exposing top-of-stack and occupancy.
module stack_controller #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDR  = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] tos,
    output logic [ADDR:0]    sp,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] mem_x,
    output logic [ADDR-1:0]  mem_ind1,
    output logic [ADDR-1:0]  mem_ind2,
    output logic             mem_beta,
    input  logic [WIDTH-1:0] mem_out1,
    input  logic [WIDTH-1:0] mem_out2
);
    localparam int unsigned DEPTH   = 2**ADDR;
    localparam logic [ADDR:0] SP_FULL = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] SP_TWO  = (ADDR+1)'(2);

    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, WRITE2} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] tmp_q;
    logic [ADDR:0]    sp_nxt;
    logic [ADDR-1:0]  new_idx, top_idx, sec_idx;
    logic             op_err;
    logic             beta_c;

    assign new_idx = sp[ADDR-1:0];
    assign top_idx = new_idx - ADDR'(1);
    assign sec_idx = new_idx - ADDR'(2);
    assign empty   = (sp == '0);
    assign full    = (sp == SP_FULL);
    assign tos     = empty ? '0 : mem_out1;
    // No memory write may land on an edge where reset is sampled.
    assign mem_beta = beta_c & ~reset;

    // Over/underflow of the latched command against the pre-op pointer.
    always_comb begin
        op_err = 1'b0;
        case (op_q)
            OP_PUSH:                 op_err = full;
            OP_POP:                  op_err = empty;
            OP_DUP:                  op_err = full | empty;
            OP_ADD, OP_SUB, OP_SWAP: op_err = (sp < SP_TWO);
            default:                 op_err = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = EXEC;
            EXEC:    state_nxt = (op_q == OP_SWAP && !op_err) ? WRITE2 : IDLE;
            WRITE2:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Indices, write enable and pointer update; independent of read data.
    always_comb begin
        cmd_ready = (state == IDLE);
        mem_ind1  = top_idx;
        mem_ind2  = sec_idx;
        beta_c    = 1'b0;
        sp_nxt    = sp;
        if (state == EXEC && !op_err) begin
            case (op_q)
                OP_PUSH: begin
                    mem_ind1 = new_idx;
                    beta_c   = 1'b1;
                    sp_nxt   = sp + (ADDR+1)'(1);
                end
                OP_POP: sp_nxt = sp - (ADDR+1)'(1);
                OP_ADD, OP_SUB: begin
                    mem_ind1 = sec_idx;
                    mem_ind2 = top_idx;
                    beta_c   = 1'b1;
                    sp_nxt   = sp - (ADDR+1)'(1);
                end
                OP_DUP: begin
                    mem_ind1 = new_idx;
                    mem_ind2 = top_idx;
                    beta_c   = 1'b1;
                    sp_nxt   = sp + (ADDR+1)'(1);
                end
                OP_SWAP: beta_c = 1'b1;
                default: ;
            endcase
        end else if (state == WRITE2) begin
            mem_ind1 = sec_idx;
            beta_c   = 1'b1;
        end
    end

    // Write data path; kept apart from the index logic so read data never loops back.
    always_comb begin
        mem_x = '0;
        if (state == EXEC) begin
            case (op_q)
                OP_PUSH:          mem_x = data_q;
                OP_ADD:           mem_x = mem_out1 + mem_out2;
                OP_SUB:           mem_x = mem_out1 - mem_out2;
                OP_DUP, OP_SWAP:  mem_x = mem_out2;
                default:          mem_x = '0;
            endcase
        end else if (state == WRITE2) begin
            mem_x = tmp_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp     <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            op_q   <= '0;
            data_q <= '0;
            tmp_q  <= '0;
        end else begin
            sp   <= sp_nxt;
            done <= (state == EXEC && state_nxt == IDLE) || (state == WRITE2);
            err  <= (state == EXEC) && op_err;
            if (state == IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
            // Old top, written to the second slot by WRITE2.
            if (state == EXEC) tmp_q <= mem_out1;
        end
    end
endmodule
